// File: rtl/dna_ip_reg_dna_reader.sv
`default_nettype none
// ============================================================================
// dna_ip_reg_dna_reader : AXI-Lite register bank + DNA_PORT serial read sequencer
// Rev 1.0
// ============================================================================
module dna_ip_reg_dna_reader #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          DNA_WIDTH  = 57,
    parameter int          CLK_DIV    = 2,
    parameter logic [31:0] IP_ID      = 32'h444E_4101
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [3:0]            i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_data_w,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_data_r,
    output logic                  o_dna_read,
    output logic                  o_dna_shift,
    output logic                  o_dna_clk,
    input  logic                  i_dna_dout,
    output logic                  o_busy
);

    localparam logic [2:0] WORD_CTRL    = 3'd0;
    localparam logic [2:0] WORD_STATUS  = 3'd1;
    localparam logic [2:0] WORD_DNA_LO  = 3'd2;
    localparam logic [2:0] WORD_DNA_HI  = 3'd3;
    localparam logic [2:0] WORD_SCRATCH = 3'd4;
    localparam logic [2:0] WORD_ID      = 3'd5;

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]     BIT_LAST = 7'(DNA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [DIV_W-1:0]     div_cnt, div_cnt_nx;
    logic                 phase, phase_nx;
    logic [6:0]           bit_cnt, bit_cnt_nx;
    logic [DNA_WIDTH-1:0] sr, sr_nx;
    logic [DNA_WIDTH-1:0] dna, dna_nx;
    logic                 busy, busy_nx;
    logic                 done, done_nx;
    logic                 valid, valid_nx;
    logic                 dna_read, dna_read_nx;
    logic                 dna_shift, dna_shift_nx;
    logic [31:0]          scratch;

    logic [2:0]           wr_word;
    logic [2:0]           rd_word;
    logic                 wr_commit;
    logic                 start_req;
    logic                 half_end;
    logic [63:0]          dna_ext;
    logic                 unused_addr_bits;

    assign wr_word   = i_addr_w[4:2];
    assign rd_word   = i_addr_r[4:2];
    assign wr_commit = |i_wen;
    assign start_req = wr_commit && (wr_word == WORD_CTRL) && i_wen[0] && i_data_w[0];
    assign half_end  = (div_cnt == DIV_LAST);
    assign dna_ext   = 64'(dna);

    assign unused_addr_bits = ^{i_addr_w[ADDR_WIDTH-1:5], i_addr_w[1:0],
                                i_addr_r[ADDR_WIDTH-1:5], i_addr_r[1:0]};

    // SCRATCH: byte-granular writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scratch <= '0;
        end else if (wr_commit && (wr_word == WORD_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wen[b]) begin
                    scratch[b*8 +: 8] <= i_data_w[b*8 +: 8];
                end
            end
        end
    end

    // Sequencer state; strobes and dna_clk are flops so the primitive sees clean edges
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            sr        <= '0;
            dna       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_cnt_nx;
            phase     <= phase_nx;
            bit_cnt   <= bit_cnt_nx;
            sr        <= sr_nx;
            dna       <= dna_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            valid     <= valid_nx;
            dna_read  <= dna_read_nx;
            dna_shift <= dna_shift_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        div_cnt_nx   = div_cnt;
        phase_nx     = phase;
        bit_cnt_nx   = bit_cnt;
        sr_nx        = sr;
        dna_nx       = dna;
        busy_nx      = busy;
        done_nx      = done;
        valid_nx     = valid;
        dna_read_nx  = 1'b0;
        dna_shift_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start_req) begin
                    state_nx    = LOAD;
                    busy_nx     = 1'b1;
                    done_nx     = 1'b0;
                    div_cnt_nx  = '0;
                    phase_nx    = 1'b0;
                    dna_read_nx = 1'b1;
                end
            end

            LOAD: begin
                dna_read_nx = 1'b1;
                if (half_end) begin
                    div_cnt_nx = '0;
                    phase_nx   = ~phase;
                    if (phase) begin
                        state_nx     = SHIFT;
                        bit_cnt_nx   = '0;
                        dna_read_nx  = 1'b0;
                        dna_shift_nx = 1'b1;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                dna_shift_nx = 1'b1;
                if (half_end) begin
                    div_cnt_nx = '0;
                    phase_nx   = ~phase;
                    if (!phase) begin
                        // last low cycle: DOUT is stable before the coming rising edge
                        sr_nx = DNA_WIDTH'({sr, i_dna_dout});
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nx     = IDLE;
                        dna_nx       = sr;
                        busy_nx      = 1'b0;
                        done_nx      = 1'b1;
                        valid_nx     = 1'b1;
                        dna_shift_nx = 1'b0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        o_data_r = '0;
        case (rd_word)
            WORD_STATUS:  o_data_r = DATA_WIDTH'({valid, done, busy});
            WORD_DNA_LO:  o_data_r = DATA_WIDTH'(dna_ext[31:0]);
            WORD_DNA_HI:  o_data_r = DATA_WIDTH'(dna_ext[63:32]);
            WORD_SCRATCH: o_data_r = DATA_WIDTH'(scratch);
            WORD_ID:      o_data_r = DATA_WIDTH'(IP_ID);
            default:      o_data_r = '0;
        endcase
    end

    assign o_dna_read  = dna_read;
    assign o_dna_shift = dna_shift;
    assign o_dna_clk   = phase;
    assign o_busy      = busy;

endmodule
`default_nettype wire

// File: tb/tb_dna_ip_reg_dna_reader.sv
`default_nettype none
// Bench for dna_ip_reg_dna_reader: directed stimulus, queue-based scoreboard,
// two instances (CLK_DIV=2 and CLK_DIV=1) each with a DNA_PORT behavioural model.
module tb_dna_ip_reg_dna_reader;

    localparam logic [56:0] DNA_VAL = 57'h1_2345_6789_ABCD_EF;
    localparam logic [31:0] ID_VAL  = 32'h444E_4101;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  wen;
    logic [31:0] addr_w, data_w, addr_r;
    logic [31:0] data_r_a, data_r_b;
    logic        read_a, shift_a, dclk_a, busy_a;
    logic        read_b, shift_b, dclk_b, busy_b;
    logic [56:0] prim_a = '0;
    logic [56:0] prim_b = '0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dna_ip_reg_dna_reader #(.CLK_DIV(2)) dut_a (
        .clk(clk), .resetn(resetn), .i_wen(wen), .i_addr_w(addr_w), .i_data_w(data_w),
        .i_addr_r(addr_r), .o_data_r(data_r_a), .o_dna_read(read_a), .o_dna_shift(shift_a),
        .o_dna_clk(dclk_a), .i_dna_dout(prim_a[56]), .o_busy(busy_a)
    );

    dna_ip_reg_dna_reader #(.CLK_DIV(1)) dut_b (
        .clk(clk), .resetn(resetn), .i_wen(wen), .i_addr_w(addr_w), .i_data_w(data_w),
        .i_addr_r(addr_r), .o_data_r(data_r_b), .o_dna_read(read_b), .o_dna_shift(shift_b),
        .o_dna_clk(dclk_b), .i_dna_dout(prim_b[56]), .o_busy(busy_b)
    );

    // DNA_PORT models: READ loads on rising CLK, SHIFT moves next bit to DOUT (MSB first)
    always @(posedge dclk_a) begin
        if (read_a)       prim_a <= DNA_VAL;
        else if (shift_a) prim_a <= {prim_a[55:0], 1'b0};
    end
    always @(posedge dclk_b) begin
        if (read_b)       prim_b <= DNA_VAL;
        else if (shift_b) prim_b <= {prim_b[55:0], 1'b0};
    end

    // scoreboard: sel 0 = dut_a read data, 1 = dut_a pins {read,shift,clk,busy}, 2 = dut_b read data
    logic [1:0]  sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  mon_sel;
    logic [31:0] mon_exp, mon_act;
    string       mon_name;

    always @(negedge clk) begin
        if (rd_req) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got a read with no expected value");
            end else begin
                mon_sel  = sel_q.pop_front();
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                case (mon_sel)
                    2'd0:    mon_act = data_r_a;
                    2'd1:    mon_act = {28'd0, read_a, shift_a, dclk_a, busy_a};
                    default: mon_act = data_r_b;
                endcase
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic check(input logic [1:0] sel, input logic [31:0] addr,
                         input logic [31:0] exp, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        addr_r = addr;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr_w = a;
        data_w = d;
        wen    = s;
        @(posedge clk);
        #1;
        wen = 4'h0;
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    int e0;

    initial begin
        resetn = 1'b0;
        wen    = 4'h0;
        addr_w = '0;
        data_w = '0;
        addr_r = '0;
        repeat (2) @(posedge clk);
        #1;
        check(2'd1, 32'h0, 32'h0, "reset_pins");
        resetn = 1'b1;

        // reset state of the map; upper and low address bits are ignored
        check(2'd0, 32'h1000_0017, ID_VAL, "id");
        check(2'd0, 32'h04, 32'h0, "status_reset");
        check(2'd0, 32'h08, 32'h0, "dna_lo_reset");
        check(2'd0, 32'h0C, 32'h0, "dna_hi_reset");
        check(2'd0, 32'h10, 32'h0, "scratch_reset");
        check(2'd0, 32'h1C, 32'h0, "word7");
        check(2'd0, 32'h00, 32'h0, "ctrl_reads_0");

        // SCRATCH byte strobes, and old value on same-cycle read
        wr(32'h10, 32'hA5A5_A5A5, 4'hF);
        wr(32'hFFFF_FF12, 32'h1234_5678, 4'b0101);
        check(2'd0, 32'h10, 32'hA534_A578, "scratch_bytes");
        fork
            wr(32'h10, 32'hDEAD_BEEF, 4'hF);
            check(2'd0, 32'h10, 32'hA534_A578, "scratch_same_cycle");
        join
        check(2'd0, 32'h10, 32'hDEAD_BEEF, "scratch_after");

        // full DNA read; dut_b (CLK_DIV=1) finishes at 116, dut_a at 232
        wr(32'h0, 32'h1, 4'h1);
        e0 = cyc;
        check(2'd1, 32'h0, 32'h9, "pins_load");
        check(2'd0, 32'h04, 32'h1, "status_busy");
        goto(e0 + 115);
        check(2'd2, 32'h04, 32'h1, "b_status_115");
        check(2'd2, 32'h04, 32'h6, "b_status_116");
        check(2'd2, 32'h08, 32'h89AB_CDEF, "b_dna_lo");
        check(2'd2, 32'h0C, 32'h0123_4567, "b_dna_hi");
        goto(e0 + 231);
        check(2'd0, 32'h04, 32'h1, "status_231");
        check(2'd0, 32'h04, 32'h6, "status_232");
        check(2'd1, 32'h0, 32'h0, "pins_idle");
        check(2'd0, 32'h08, 32'h89AB_CDEF, "dna_lo");
        check(2'd0, 32'h0C, 32'h0123_4567, "dna_hi");

        // START while busy is ignored, even with other CTRL bits set
        wr(32'h0, 32'h1, 4'h1);
        e0 = cyc;
        goto(e0 + 50);
        wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        check(2'd0, 32'h08, 32'h89AB_CDEF, "dna_lo_kept");
        goto(e0 + 231);
        check(2'd0, 32'h04, 32'h5, "restart_231");
        check(2'd0, 32'h04, 32'h6, "restart_232");
        goto(e0 + 240);
        check(2'd0, 32'h04, 32'h6, "no_restart");
        check(2'd2, 32'h04, 32'h6, "b_no_restart");

        // asynchronous reset mid-read
        wr(32'h0, 32'h1, 4'h1);
        e0 = cyc;
        goto(e0 + 98);
        check(2'd1, 32'h0, 32'h7, "pins_shift");
        goto(e0 + 100);
        resetn = 1'b0;
        check(2'd1, 32'h0, 32'h0, "pins_async_reset");
        check(2'd0, 32'h04, 32'h0, "status_after_reset");
        check(2'd0, 32'h08, 32'h0, "dna_lo_after_reset");
        check(2'd0, 32'h0C, 32'h0, "dna_hi_after_reset");
        check(2'd0, 32'h10, 32'h0, "scratch_after_reset");
        resetn = 1'b1;
        wr(32'h0, 32'h1, 4'h1);
        e0 = cyc;
        goto(e0 + 231);
        check(2'd0, 32'h04, 32'h1, "again_231");
        check(2'd0, 32'h04, 32'h6, "again_232");
        check(2'd0, 32'h08, 32'h89AB_CDEF, "again_dna_lo");
        check(2'd0, 32'h0C, 32'h0123_4567, "again_dna_hi");

        // writes to read-only and unmapped words have no effect
        wr(32'h04, 32'hFFFF_FFFF, 4'hF);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        wr(32'h14, 32'hFFFF_FFFF, 4'hF);
        wr(32'h18, 32'hFFFF_FFFF, 4'hF);
        check(2'd0, 32'h04, 32'h6, "ro_status");
        check(2'd0, 32'h08, 32'h89AB_CDEF, "ro_dna_lo");
        check(2'd0, 32'h0C, 32'h0123_4567, "ro_dna_hi");
        check(2'd0, 32'h14, ID_VAL, "ro_id");
        check(2'd0, 32'h18, 32'h0, "word6");
        check(2'd0, 32'h10, 32'h0, "scratch_untouched");
        check(2'd2, 32'h0C, 32'h0123_4567, "b_final_dna_hi");

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
